// File: rtl/signed_sat_mac_if.sv
// Handshake bundle for the signed saturating MAC: operand stream in,
// frame result stream out.
interface signed_sat_mac_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_a;
  logic signed [IN_W-1:0]  in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_sat;

  // Producer of operand pairs / consumer of results
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_sat
  );

  // The MAC itself
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_sat
  );
endinterface

// File: rtl/signed_sat_mac.sv
// Streaming signed multiply-accumulate. LEN operand pairs per frame are
// multiplied (one register stage), summed with per-step saturation, and the
// frame result is presented with a sticky clamp flag.
module signed_sat_mac #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16,
  parameter int LEN   = 4
) (
  input  logic                clk,
  input  logic                rst,
  signed_sat_mac_if.slave     bus
);
  localparam int CNT_W = $clog2(LEN + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

  state_t                  state;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] out_sum_q;
  logic                    out_sat_q;
  logic [CNT_W-1:0]        count;
  logic signed [ACC_W-1:0] acc;
  logic                    sticky;
  logic signed [ACC_W-1:0] prod_reg;
  logic                    prod_vld;

  logic                    accept;
  logic signed [2*IN_W-1:0] a_ext, b_ext, prod_full;
  logic signed [ACC_W-1:0] prod_ext;
  logic        [ACC_W:0]   sum_wide;
  logic                    ovf;
  logic signed [ACC_W-1:0] acc_next;

  assign accept = bus.in_valid && in_ready_q;

  // Full-width signed product, then sign-extended to the accumulator width
  assign a_ext     = (2*IN_W)'(bus.in_a);
  assign b_ext     = (2*IN_W)'(bus.in_b);
  assign prod_full = a_ext * b_ext;
  assign prod_ext  = ACC_W'(prod_full);

  // One guard bit: overflow shows up as the top two bits disagreeing, and the
  // top bit alone tells which rail to clamp to.
  assign sum_wide = {acc[ACC_W-1], acc} + {prod_reg[ACC_W-1], prod_reg};
  assign ovf      = sum_wide[ACC_W] != sum_wide[ACC_W-1];
  assign acc_next = !ovf            ? sum_wide[ACC_W-1:0] :
                    sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_sat   = out_sat_q;

  // Product register stage: captures a product on every accepted pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_reg <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= accept;
      if (accept) prod_reg <= prod_ext;
    end
  end

  // Frame FSM with accumulator; DRAIN waits for the product stage to empty
  // so the published sum includes the last product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      count       <= '0;
      acc         <= '0;
      sticky      <= 1'b0;
    end else begin
      if (prod_vld) begin
        acc <= acc_next;
        if (ovf) sticky <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            count <= CNT_W'(1);
            if (LEN == 1) begin
              state      <= DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            count <= count + CNT_W'(1);
            if (count == CNT_W'(LEN - 1)) begin
              state      <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!prod_vld) begin
            out_sum_q   <= acc;
            out_sat_q   <= sticky;
            out_valid_q <= 1'b1;
            state       <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            acc         <= '0;
            sticky      <= 1'b0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_sat_mac.sv
// Bench for signed_sat_mac: directed frame table, backpressure and reset
// sequences, then random frames against an integer reference model.
module tb_signed_sat_mac;
  localparam int LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  signed_sat_mac_if bus ();
  signed_sat_mac dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  logic signed [7:0] fa [LEN];
  logic signed [7:0] fb [LEN];

  typedef struct {
    logic [LEN-1:0][7:0] a;
    logic [LEN-1:0][7:0] b;
    logic [15:0]         es;
    bit                  sat;
    int                  stall;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer accumulation, clamped after every product
  function automatic void model(output longint s, output bit st);
    longint a;
    a  = 0;
    st = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      a = a + longint'(fa[i]) * longint'(fb[i]);
      if (a > 32767)       begin a = 32767;  st = 1'b1; end
      else if (a < -32768) begin a = -32768; st = 1'b1; end
    end
    s = a;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [15:0] es, input bit sat, input int stall);
    vec_t v;
    v.a = a; v.b = b; v.es = es; v.sat = sat; v.stall = stall;
    return v;
  endfunction

  // Drives fa/fb as one frame (optional random gaps), checks latency, result,
  // hold under backpressure and the release handshake.
  task automatic send_frame(input string nm, input int gap_max, input int stall,
                            input longint es, input bit esat);
    int lat;
    int g;
    for (int i = 0; i < LEN; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int k = 0; k < g; k++) begin
        bus.in_valid = 1'b0;
        bus.in_a = 8'($urandom);
        bus.in_b = 8'($urandom);
        tick();
      end
      chk({nm, " in_ready"}, bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_a = fa[i];
      bus.in_b = fb[i];
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_a = 8'($urandom);
    bus.in_b = 8'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, lat, 2);
    chk({nm, " sum"}, $signed(bus.out_sum), es);
    chk({nm, " sat"}, bus.out_sat, esat);
    for (int s = 0; s < stall; s++) begin
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a = 8'($urandom);
      bus.in_b = 8'($urandom);
      tick();
      chk({nm, " hold valid"}, bus.out_valid, 1);
      chk({nm, " hold sum"}, $signed(bus.out_sum), es);
      chk({nm, " hold sat"}, bus.out_sat, esat);
      chk({nm, " hold in_ready"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk({nm, " valid drop"}, bus.out_valid, 0);
    chk({nm, " ready back"}, bus.in_ready, 1);
    chk({nm, " sum kept"}, $signed(bus.out_sum), es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pick [6];
    longint es;
    bit     est;

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    pick[0] = 8'h80; pick[1] = 8'h7F; pick[2] = 8'h81;
    pick[3] = 8'h00; pick[4] = 8'h01; pick[5] = 8'hFF;

    // byte 0 of each packed word is the first pair of the frame
    tbl[0] = mk(32'h80808080, 32'h80808080, 16'h7FFF, 1'b1, 0);
    tbl[1] = mk(32'h80808080, 32'h7F7F7F7F, 16'h8000, 1'b1, 0);
    tbl[2] = mk(32'h0001807F, 32'h55FF0101, 16'hFFFE, 1'b0, 5);
    tbl[3] = mk(32'h01010101, 32'h01010101, 16'h0004, 1'b0, 0);
    tbl[4] = mk(32'h7F7F7F7F, 32'h7F7F7F7F, 16'h7FFF, 1'b1, 1);
    tbl[5] = mk(32'h7F7F8181, 32'h7F7F7F7F, 16'h0000, 1'b0, 0);
    tbl[6] = mk(32'h80808080, 32'h7F7F8080, 16'h00FF, 1'b1, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_sum", bus.out_sum, 0);
    chk("reset out_sat", bus.out_sat, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < LEN; i++) begin
        fa[i] = tbl[t].a[i];
        fb[i] = tbl[t].b[i];
      end
      send_frame($sformatf("vec%0d", t), 0, tbl[t].stall,
                 longint'($signed(tbl[t].es)), tbl[t].sat);
    end

    // Reset in the middle of a frame discards it, including the pending product
    bus.in_valid = 1'b1; bus.in_a = 8'h7F; bus.in_b = 8'h7F;
    tick();
    tick();
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst out_sum", bus.out_sum, 0);
    chk("midrst out_sat", bus.out_sat, 0);
    chk("midrst in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < LEN; i++) begin fa[i] = 8'sd2; fb[i] = 8'sd3; end
    send_frame("after reset", 0, 0, 24, 1'b0);

    // Random frames with input gaps and output stalls
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < LEN; i++) begin
        if (f % 3 == 0) begin
          fa[i] = pick[$urandom_range(0, 5)];
          fb[i] = pick[$urandom_range(0, 5)];
        end else begin
          fa[i] = 8'($urandom);
          fb[i] = 8'($urandom);
        end
      end
      model(es, est);
      send_frame($sformatf("rand%0d", f), 2, int'($urandom_range(0, 3)), es, est);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
